muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the Extended MIPS core.
//  - Sits downstream of the register file: operands come from the rdata1/rdata2 ports (rs, rt).
//  - Its hi/lo outputs return to the write-back path via MFHI/MFLO.
//  - Executes MULT, MULTU, DIV and DIVU over multiple cycles; the pipeline stalls on busy.

---
 rtl/muldiv_unit_if.sv | 18 +
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the pipeline (master) and muldiv_unit (slave).
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; done WIDTH+1 cycles after start, pipeline stalls on busy.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (done one cycle after start).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_lo;
  logic               r_neg_hi;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.a[WIDTH-1];
  assign w_sb     = w_signed & bus.b[WIDTH-1];
  assign w_ma     = w_sa ? -bus.a : bus.a;
  assign w_mb     = w_sb ? -bus.b : bus.b;

  // Multiply: r_p = {partial upper, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide: r_p = {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign w_trial    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_lo ? -r_p : r_p;
  assign w_quo_fix  = r_neg_lo ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  // Divide by zero leaves remainder = |a|, so the remainder fix-up already yields hi = a.
  assign w_hi_fix   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_fix   = r_is_div ? (r_dz ? '1 : w_quo_fix) : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_dz     <= bus.op[1] & (bus.b == '0);
            r_neg_lo <= w_sa ^ w_sb;
            if (bus.op[1]) begin
              r_p      <= {{WIDTH{1'b0}}, w_ma};
              r_opnd   <= w_mb;
              r_neg_hi <= w_sa;
              r_state  <= S_DIV;
            end else begin
              r_neg_hi <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              r_p      <= {{WIDTH{1'b0}}, w_ma} * {{WIDTH{1'b0}}, w_mb};
              r_state  <= S_FIN;
`else
              r_p      <= {{WIDTH{1'b0}}, w_mb};
              r_opnd   <= w_ma;
              r_state  <= S_MUL;
`endif
            end
          end else begin
            if (bus.mthi) r_hi <= bus.a;
            if (bus.mtlo) r_lo <= bus.a;
          end
        end
        S_MUL: begin
          r_p   <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) r_state <= S_FIN;
        end
        S_DIV: begin
          r_p   <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) r_state <= S_FIN;
        end
        S_FIN: begin
          // First FIN edge publishes the result; the second releases busy.
          if (!r_done) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed self-checking bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = {32'd0, a} * {32'd0, b};
      2'b10:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return W + 1;
  endfunction

  // inj_kind: 0 none, 1 restart while busy, 2 mthi/mtlo while busy, 3 mthi/mtlo with start
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj_kind, input int inj_cyc);
    logic [63:0] want;
    int cyc;
    int gaps;
    int disturbs;
    want = ref_result(op, a, b);
    cyc = 0; gaps = 0; disturbs = 0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (inj_kind == 3) begin bus.mthi = 1'b1; bus.mtlo = 1'b1; end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy !== 1'b1) gaps++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) disturbs++;
      if (cyc == inj_cyc && inj_kind == 1) begin
        bus.start = 1'b1; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
      end
      if (cyc == inj_cyc && inj_kind == 2) begin
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.a = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      cyc++;
    end
    chk($sformatf("%s/latency", tag), 64'(cyc), 64'(exp_lat(op)));
    chk($sformatf("%s/busy_held", tag), 64'(gaps), 64'd0);
    chk($sformatf("%s/hilo_hold", tag), 64'(disturbs), 64'd0);
    chk($sformatf("%s/busy_at_done", tag), 64'(bus.busy), 64'd1);
    chk($sformatf("%s/hi", tag), 64'(bus.hi), 64'(want[63:32]));
    chk($sformatf("%s/lo", tag), 64'(bus.lo), 64'(want[31:0]));
    m_hi = want[63:32];
    m_lo = want[31:0];
    @(posedge clk); #1;
    chk($sformatf("%s/done_pulse", tag), 64'(bus.done), 64'd0);
    chk($sformatf("%s/busy_release", tag), 64'(bus.busy), 64'd0);
    chk($sformatf("%s/result_kept", tag), {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  task automatic do_mt(input logic h, input logic l, input logic [W-1:0] v);
    bus.mthi = h; bus.mtlo = l; bus.a = v;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    chk("mt_hi", 64'(bus.hi), 64'(m_hi));
    chk("mt_lo", 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("divu_zero",  2'b11, 32'd7, 32'd0, 0, 0);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 5);
    run_op("div_zero_n", 2'b10, 32'hFFFF_FFF0, 32'd0, 0, 0);
    do_mt(1'b1, 1'b0, 32'h0000_1234);
    do_mt(1'b0, 1'b1, 32'hCAFE_0001);
    do_mt(1'b1, 1'b1, 32'h5555_AAAA);
    run_op("divu_mt_busy", 2'b11, 32'd100, 32'd7, 2, 3);
    run_op("start_with_mt", 2'b01, 32'd5, 32'd6, 3, 0);

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midop_rst_busy", 64'(bus.busy), 64'd0);
    chk("midop_rst_done", 64'(bus.done), 64'd0);
    chk("midop_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op("after_rst", 2'b10, 32'd1000, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 3), $urandom_range(0, 20));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
